irrigation_scheduler: RTL and testbench

IRRIGATION_SCHEDULER -- requirements
Module: irrigation_scheduler

---
 rtl/irrigation_scheduler_if.sv | 34 +++
 rtl/irrigation_scheduler.sv | 122 ++++++++++++
 tb/tb_irrigation_scheduler.sv | 332 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/irrigation_scheduler_if.sv
// Irrigation scheduler signal bundle.
// Sensors and tick flow in; actuator and status decodes flow out.
interface irrigation_scheduler_if;
    logic        tick;
    logic        low_water_level;
    logic        mid_water_level;
    logic        high_water_level;
    logic        earth_dry;
    logic        air_humidity;
    logic        low_temperature;
    logic        request;
    logic        sprinkler_on;
    logic        dripper_on;
    logic        supply_valve_on;
    logic        alarm;
    logic        busy;
    logic        done;
    logic [2:0]  state;
    logic [11:0] remaining;

    modport master (
        output tick, low_water_level, mid_water_level, high_water_level,
        output earth_dry, air_humidity, low_temperature, request,
        input  sprinkler_on, dripper_on, supply_valve_on, alarm,
        input  busy, done, state, remaining
    );

    modport slave (
        input  tick, low_water_level, mid_water_level, high_water_level,
        input  earth_dry, air_humidity, low_temperature, request,
        output sprinkler_on, dripper_on, supply_valve_on, alarm,
        output busy, done, state, remaining
    );
endinterface

// File: rtl/irrigation_scheduler.sv
// Tank-aware irrigation controller: sprinkler/dripper runs,
// pause on low water, refill, and latched sensor fault handling.
module irrigation_scheduler #(
    parameter int SPRINKLER_SECONDS = 600,
    parameter int DRIPPER_SECONDS   = 1800
) (
    input logic clock,
    input logic reset,
    irrigation_scheduler_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        IRRIGATE = 3'd1,
        PAUSE    = 3'd2,
        REFILL   = 3'd3,
        FAULT    = 3'd4
    } state_t;

    localparam logic [11:0] SPR_LOAD = 12'(SPRINKLER_SECONDS);
    localparam logic [11:0] DRP_LOAD = 12'(DRIPPER_SECONDS);

    state_t      state_q, state_n;
    logic [11:0] rem_q, rem_n;
    logic        mode_q, mode_n;
    logic        done_q, done_n;
    logic        mid_low_q;
    logic [2:0]  levels;
    logic        sensor_err;
    logic        sprinkler_pick;

    assign levels = {bus.high_water_level, bus.mid_water_level,
                     bus.low_water_level};

    // Probes are stacked, so only contiguous wet-from-bottom patterns are real.
    always_comb begin
        sensor_err = 1'b1;
        case (levels)
            3'b000, 3'b001, 3'b011, 3'b111: sensor_err = 1'b0;
            default:                        sensor_err = 1'b1;
        endcase
    end

    assign sprinkler_pick = !bus.air_humidity && !bus.low_temperature
                            && bus.mid_water_level;

    // State, run counter, mode, done pulse and mid-level alarm registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            rem_q     <= '0;
            mode_q    <= 1'b0;
            done_q    <= 1'b0;
            mid_low_q <= 1'b0;
        end else begin
            state_q   <= state_n;
            rem_q     <= rem_n;
            mode_q    <= mode_n;
            done_q    <= done_n;
            mid_low_q <= !bus.mid_water_level;
        end
    end

    // Next-state, counter and mode selection; sensor fault overrides all.
    always_comb begin
        state_n = state_q;
        rem_n   = rem_q;
        mode_n  = mode_q;
        done_n  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!bus.low_water_level) begin
                    state_n = REFILL;
                end else if (bus.earth_dry || bus.request) begin
                    state_n = IRRIGATE;
                    mode_n  = sprinkler_pick;
                    rem_n   = sprinkler_pick ? SPR_LOAD : DRP_LOAD;
                end
            end
            IRRIGATE: begin
                if (!bus.low_water_level) begin
                    state_n = PAUSE;
                end else if (bus.tick) begin
                    if (rem_q <= 12'd1) begin
                        rem_n   = '0;
                        done_n  = 1'b1;
                        state_n = IDLE;
                    end else begin
                        rem_n = rem_q - 12'd1;
                    end
                end
            end
            PAUSE: begin
                if (bus.high_water_level) state_n = IRRIGATE;
            end
            REFILL: begin
                if (bus.high_water_level) state_n = IDLE;
            end
            FAULT: begin
                if (bus.request && !sensor_err) begin
                    state_n = IDLE;
                    rem_n   = '0;
                end
            end
            default: state_n = FAULT;
        endcase
        if (sensor_err && state_q != FAULT) begin
            state_n = FAULT;
            rem_n   = rem_q;
            mode_n  = mode_q;
            done_n  = 1'b0;
        end
    end

    assign bus.state           = state_q;
    assign bus.remaining       = rem_q;
    assign bus.done            = done_q;
    assign bus.sprinkler_on    = (state_q == IRRIGATE) && mode_q;
    assign bus.dripper_on      = (state_q == IRRIGATE) && !mode_q;
    assign bus.supply_valve_on = (state_q == PAUSE) || (state_q == REFILL);
    assign bus.busy            = (state_q == IRRIGATE) || (state_q == PAUSE);
    assign bus.alarm           = (state_q == FAULT) || mid_low_q;
endmodule

// File: tb/tb_irrigation_scheduler.sv
// Directed bench for the irrigation scheduler.
// Each task drives a scenario and checks against hand-computed values.
module tb_irrigation_scheduler;
    logic clock;
    logic reset;
    int   checks;
    int   errors;

    irrigation_scheduler_if bus ();

    irrigation_scheduler #(
        .SPRINKLER_SECONDS(600),
        .DRIPPER_SECONDS  (1800)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_levels(input logic h, input logic m, input logic l);
        bus.high_water_level = h;
        bus.mid_water_level  = m;
        bus.low_water_level  = l;
    endtask

    task automatic do_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            bus.tick = 1'b1;
            step();
            bus.tick = 1'b0;
            step();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        checks++;
        if (bus.state !== 3'd0) begin
            errors++;
            $display("FAIL rst_state got %0d want 0", bus.state);
        end
        checks++;
        if (bus.remaining !== 12'd0) begin
            errors++;
            $display("FAIL rst_remaining got %0d want 0", bus.remaining);
        end
        checks++;
        if ({bus.sprinkler_on, bus.dripper_on, bus.supply_valve_on,
             bus.alarm, bus.busy, bus.done} !== 6'b0) begin
            errors++;
            $display("FAIL rst_outputs got %b want 000000",
                     {bus.sprinkler_on, bus.dripper_on, bus.supply_valve_on,
                      bus.alarm, bus.busy, bus.done});
        end
        reset = 1'b0;
        step();
        checks++;
        if (bus.state !== 3'd0) begin
            errors++;
            $display("FAIL rst_idle_hold got %0d want 0", bus.state);
        end
    endtask

    task automatic test_sprinkler();
        bus.earth_dry = 1'b1;
        step();
        bus.earth_dry = 1'b0;
        checks++;
        if (bus.state !== 3'd1 || bus.sprinkler_on !== 1'b1
            || bus.dripper_on !== 1'b0 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL spr_start got st=%0d s=%b d=%b b=%b want 1/1/0/1",
                     bus.state, bus.sprinkler_on, bus.dripper_on, bus.busy);
        end
        checks++;
        if (bus.remaining !== 12'd600) begin
            errors++;
            $display("FAIL spr_load got %0d want 600", bus.remaining);
        end
        do_ticks(599);
        checks++;
        if (bus.remaining !== 12'd1 || bus.state !== 3'd1) begin
            errors++;
            $display("FAIL spr_last got rem=%0d st=%0d want 1/1",
                     bus.remaining, bus.state);
        end
        bus.tick = 1'b1;
        step();
        bus.tick = 1'b0;
        checks++;
        if (bus.state !== 3'd0 || bus.done !== 1'b1
            || bus.remaining !== 12'd0 || bus.sprinkler_on !== 1'b0) begin
            errors++;
            $display("FAIL spr_done got st=%0d done=%b rem=%0d s=%b want 0/1/0/0",
                     bus.state, bus.done, bus.remaining, bus.sprinkler_on);
        end
        step();
        checks++;
        if (bus.done !== 1'b0 || bus.state !== 3'd0) begin
            errors++;
            $display("FAIL spr_done_pulse got done=%b st=%0d want 0/0",
                     bus.done, bus.state);
        end
    endtask

    task automatic test_dripper();
        set_levels(1'b0, 1'b0, 1'b1);
        bus.request = 1'b1;
        step();
        bus.request = 1'b0;
        checks++;
        if (bus.state !== 3'd1 || bus.dripper_on !== 1'b1
            || bus.sprinkler_on !== 1'b0) begin
            errors++;
            $display("FAIL drp_start got st=%0d d=%b s=%b want 1/1/0",
                     bus.state, bus.dripper_on, bus.sprinkler_on);
        end
        checks++;
        if (bus.remaining !== 12'd1800) begin
            errors++;
            $display("FAIL drp_load got %0d want 1800", bus.remaining);
        end
        checks++;
        if (bus.alarm !== 1'b1) begin
            errors++;
            $display("FAIL drp_mid_alarm got %b want 1", bus.alarm);
        end
        do_ticks(5);
        checks++;
        if (bus.remaining !== 12'd1795) begin
            errors++;
            $display("FAIL drp_count got %0d want 1795", bus.remaining);
        end
    endtask

    task automatic test_request_ignored();
        bus.request = 1'b1;
        step();
        bus.request = 1'b0;
        checks++;
        if (bus.state !== 3'd1 || bus.remaining !== 12'd1795) begin
            errors++;
            $display("FAIL req_ignored got st=%0d rem=%0d want 1/1795",
                     bus.state, bus.remaining);
        end
    endtask

    task automatic test_pause();
        do_ticks(1545);
        checks++;
        if (bus.remaining !== 12'd250) begin
            errors++;
            $display("FAIL pse_pre got %0d want 250", bus.remaining);
        end
        set_levels(1'b0, 1'b0, 1'b0);
        bus.tick = 1'b1;
        step();
        bus.tick = 1'b0;
        checks++;
        if (bus.state !== 3'd2 || bus.supply_valve_on !== 1'b1
            || bus.busy !== 1'b1 || bus.dripper_on !== 1'b0) begin
            errors++;
            $display("FAIL pse_enter got st=%0d v=%b b=%b d=%b want 2/1/1/0",
                     bus.state, bus.supply_valve_on, bus.busy, bus.dripper_on);
        end
        checks++;
        if (bus.remaining !== 12'd250) begin
            errors++;
            $display("FAIL pse_hold got %0d want 250", bus.remaining);
        end
        set_levels(1'b0, 1'b1, 1'b1);
        do_ticks(3);
        checks++;
        if (bus.state !== 3'd2 || bus.remaining !== 12'd250) begin
            errors++;
            $display("FAIL pse_ticks got st=%0d rem=%0d want 2/250",
                     bus.state, bus.remaining);
        end
        set_levels(1'b1, 1'b1, 1'b1);
        step();
        checks++;
        if (bus.state !== 3'd1 || bus.remaining !== 12'd250
            || bus.dripper_on !== 1'b1 || bus.sprinkler_on !== 1'b0) begin
            errors++;
            $display("FAIL pse_resume got st=%0d rem=%0d d=%b s=%b want 1/250/1/0",
                     bus.state, bus.remaining, bus.dripper_on, bus.sprinkler_on);
        end
    endtask

    task automatic test_fault();
        set_levels(1'b1, 1'b0, 1'b1);
        step();
        checks++;
        if (bus.state !== 3'd4 || bus.alarm !== 1'b1 || bus.busy !== 1'b0
            || bus.dripper_on !== 1'b0 || bus.sprinkler_on !== 1'b0
            || bus.supply_valve_on !== 1'b0) begin
            errors++;
            $display("FAIL flt_enter got st=%0d a=%b b=%b d=%b s=%b v=%b",
                     bus.state, bus.alarm, bus.busy, bus.dripper_on,
                     bus.sprinkler_on, bus.supply_valve_on);
        end
        bus.request = 1'b1;
        step();
        bus.request = 1'b0;
        checks++;
        if (bus.state !== 3'd4) begin
            errors++;
            $display("FAIL flt_ack_err got %0d want 4", bus.state);
        end
        set_levels(1'b1, 1'b1, 1'b1);
        step();
        checks++;
        if (bus.state !== 3'd4 || bus.alarm !== 1'b1) begin
            errors++;
            $display("FAIL flt_sticky got st=%0d a=%b want 4/1",
                     bus.state, bus.alarm);
        end
        bus.request = 1'b1;
        step();
        bus.request = 1'b0;
        checks++;
        if (bus.state !== 3'd0 || bus.remaining !== 12'd0
            || bus.alarm !== 1'b0) begin
            errors++;
            $display("FAIL flt_exit got st=%0d rem=%0d a=%b want 0/0/0",
                     bus.state, bus.remaining, bus.alarm);
        end
    endtask

    task automatic test_refill();
        set_levels(1'b0, 1'b0, 1'b0);
        step();
        checks++;
        if (bus.state !== 3'd3 || bus.supply_valve_on !== 1'b1
            || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL rfl_enter got st=%0d v=%b b=%b want 3/1/0",
                     bus.state, bus.supply_valve_on, bus.busy);
        end
        set_levels(1'b0, 1'b1, 1'b1);
        step();
        checks++;
        if (bus.state !== 3'd3) begin
            errors++;
            $display("FAIL rfl_wait got %0d want 3", bus.state);
        end
        set_levels(1'b1, 1'b1, 1'b1);
        step();
        checks++;
        if (bus.state !== 3'd0 || bus.supply_valve_on !== 1'b0) begin
            errors++;
            $display("FAIL rfl_full got st=%0d v=%b want 0/0",
                     bus.state, bus.supply_valve_on);
        end
        bus.earth_dry = 1'b1;
        step();
        bus.earth_dry = 1'b0;
        checks++;
        if (bus.state !== 3'd1 || bus.sprinkler_on !== 1'b1
            || bus.remaining !== 12'd600) begin
            errors++;
            $display("FAIL rfl_irrigate got st=%0d s=%b rem=%0d want 1/1/600",
                     bus.state, bus.sprinkler_on, bus.remaining);
        end
    endtask

    task automatic test_reset_midrun();
        do_ticks(558);
        checks++;
        if (bus.remaining !== 12'd42) begin
            errors++;
            $display("FAIL mrst_pre got %0d want 42", bus.remaining);
        end
        reset = 1'b1;
        bus.tick = 1'b1;
        bus.earth_dry = 1'b1;
        bus.request = 1'b1;
        step();
        reset = 1'b0;
        bus.tick = 1'b0;
        bus.earth_dry = 1'b0;
        bus.request = 1'b0;
        checks++;
        if (bus.state !== 3'd0 || bus.remaining !== 12'd0
            || {bus.sprinkler_on, bus.dripper_on, bus.supply_valve_on,
                bus.alarm, bus.busy, bus.done} !== 6'b0) begin
            errors++;
            $display("FAIL mrst_clear got st=%0d rem=%0d outs=%b want 0/0/0",
                     bus.state, bus.remaining,
                     {bus.sprinkler_on, bus.dripper_on, bus.supply_valve_on,
                      bus.alarm, bus.busy, bus.done});
        end
        step();
        checks++;
        if (bus.state !== 3'd0) begin
            errors++;
            $display("FAIL mrst_idle got %0d want 0", bus.state);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1;
        bus.tick = 1'b0;
        bus.earth_dry = 1'b0;
        bus.air_humidity = 1'b0;
        bus.low_temperature = 1'b0;
        bus.request = 1'b0;
        set_levels(1'b1, 1'b1, 1'b1);
        test_reset();
        test_sprinkler();
        test_dripper();
        test_request_ignored();
        test_pause();
        test_fault();
        test_refill();
        test_reset_midrun();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
